// File: rtl/rom_arb_pkg.sv
// Shared constants and state types for the cartridge ROM arbiter.
// Header byte offsets and size-unit shifts follow the iNES layout.
package rom_arb_pkg;

    localparam int PRG_SIZE_BYTE  = 4;
    localparam int CHR_SIZE_BYTE  = 5;
    localparam int PRG_UNIT_SHIFT = 14;
    localparam int CHR_UNIT_SHIFT = 13;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        OOBACK,
        ACK
    } state_e;

    typedef enum logic {
        CLIENT_PRG,
        CLIENT_CHR
    } client_e;

endpackage

// File: rtl/rom_arb.sv
// Serves the PRG and CHR ROM read streams from one external memory port,
// alternating on contention and answering out-of-range reads locally.
module rom_arb
    import rom_arb_pkg::*;
#(
    parameter int         RAMAW   = 23,
    parameter logic [7:0] OOBDATA = 8'hFF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [127:0]     header_i,
    input  logic [20:0]      promaddr_i,
    input  logic             promreq_i,
    output logic [7:0]       promdata_o,
    output logic             promack_o,
    input  logic [20:0]      cromaddr_i,
    input  logic             cromreq_i,
    output logic [7:0]       cromdata_o,
    output logic             cromack_o,
    output logic [RAMAW-1:0] ramaddr_o,
    output logic             ramreq_o,
    input  logic [7:0]       ramrdata_i,
    input  logic             ramack_i,
    output logic [1:0]       oob_o
);

    logic [RAMAW-1:0] prgLen_d, prgLen_q;
    logic [RAMAW-1:0] chrLen_d, chrLen_q;
    logic [RAMAW-1:0] prgAddr, chrAddr, selAddr;
    logic             prgOob, chrOob, selOob;
    logic             anyReq, ackBusy;
    client_e          selClient;
    logic             unusedHeader;

    state_e           state_q;
    client_e          client_q;
    client_e          last_q;
    logic             ramreq_q;
    logic [RAMAW-1:0] ramaddr_q;
    logic [7:0]       data_q;
    logic             promack_q;
    logic             cromack_q;
    logic [1:0]       oob_q;

    assign unusedHeader = ^{header_i[127:8*CHR_SIZE_BYTE+8], header_i[8*PRG_SIZE_BYTE-1:0]};

    assign prgLen_d = RAMAW'(header_i[8*PRG_SIZE_BYTE +: 8]) << PRG_UNIT_SHIFT;
    assign chrLen_d = RAMAW'(header_i[8*CHR_SIZE_BYTE +: 8]) << CHR_UNIT_SHIFT;

    // Sizes track the header every cycle, so they are already valid while reset is held.
    always_ff @(posedge clk_i) begin
        prgLen_q <= prgLen_d;
        chrLen_q <= chrLen_d;
    end

    // CHR ROM sits directly after PRG ROM, so its base equals the PRG length.
    assign prgAddr = RAMAW'(promaddr_i);
    assign chrAddr = prgLen_q + RAMAW'(cromaddr_i);
    assign prgOob  = RAMAW'(promaddr_i) >= prgLen_q;
    assign chrOob  = RAMAW'(cromaddr_i) >= chrLen_q;

    assign anyReq  = promreq_i | cromreq_i;
    // During the ack cycle the client's req is still its old request.
    assign ackBusy = promack_q | cromack_q;

    always_comb begin
        selClient = CLIENT_PRG;
        if (cromreq_i && (!promreq_i || last_q == CLIENT_PRG)) begin
            selClient = CLIENT_CHR;
        end
        selOob  = (selClient == CLIENT_CHR) ? chrOob : prgOob;
        selAddr = (selClient == CLIENT_CHR) ? chrAddr : prgAddr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            client_q  <= CLIENT_PRG;
            last_q    <= CLIENT_CHR;
            ramreq_q  <= 1'b0;
            ramaddr_q <= '0;
            data_q    <= '0;
            promack_q <= 1'b0;
            cromack_q <= 1'b0;
            oob_q     <= '0;
        end else begin
            promack_q <= 1'b0;
            cromack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyReq && !ackBusy) begin
                        client_q <= selClient;
                        if (selOob) begin
                            if (selClient == CLIENT_CHR) begin
                                oob_q[1] <= 1'b1;
                            end else begin
                                oob_q[0] <= 1'b1;
                            end
                            state_q <= OOBACK;
                        end else begin
                            ramaddr_q <= selAddr;
                            ramreq_q  <= 1'b1;
                            state_q   <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (ramack_i) begin
                        data_q   <= ramrdata_i;
                        ramreq_q <= 1'b0;
                        state_q  <= ACK;
                    end
                end
                OOBACK: begin
                    data_q  <= OOBDATA;
                    state_q <= ACK;
                end
                ACK: begin
                    if (client_q == CLIENT_CHR) begin
                        cromack_q <= 1'b1;
                    end else begin
                        promack_q <= 1'b1;
                    end
                    last_q  <= client_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign promdata_o = data_q;
    assign cromdata_o = data_q;
    assign promack_o  = promack_q;
    assign cromack_o  = cromack_q;
    assign ramaddr_o  = ramaddr_q;
    assign ramreq_o   = ramreq_q;
    assign oob_o      = oob_q;

endmodule

// File: tb/tb_rom_arb.sv
// Self-checking bench for rom_arb: a simple memory responder plus a
// behavioural model of the ROM layout, arbitration order and latencies.
module tb_rom_arb;

    localparam int RAMAW = 23;

    logic             clk = 1'b0;
    logic             resetn;
    logic [127:0]     header;
    logic [20:0]      promaddr, cromaddr;
    logic             promreq, cromreq;
    logic [7:0]       promdata, cromdata;
    logic             promack, cromack;
    logic [RAMAW-1:0] ramaddr;
    logic             ramreq;
    logic [7:0]       ramrdata;
    logic             ramack;
    logic [1:0]       oob;

    int         total = 0;
    int         bad = 0;
    int         memDelay = 1;
    int         memWait = 0;
    int         lateReq = 0;
    int         lateDone = 0;
    logic [7:0] memSeed = 8'h00;

    rom_arb #(.RAMAW(RAMAW), .OOBDATA(8'hFF)) dut (
        .clk_i(clk), .rst_ni(resetn), .header_i(header),
        .promaddr_i(promaddr), .promreq_i(promreq), .promdata_o(promdata), .promack_o(promack),
        .cromaddr_i(cromaddr), .cromreq_i(cromreq), .cromdata_o(cromdata), .cromack_o(cromack),
        .ramaddr_o(ramaddr), .ramreq_o(ramreq), .ramrdata_i(ramrdata), .ramack_i(ramack),
        .oob_o(oob)
    );

    always #5 clk = ~clk;

    // Contents of the cartridge image as seen by the bench.
    function automatic logic [7:0] memByte(input int a);
        return 8'(a * 37) ^ 8'(a >>> 8) ^ 8'(a >>> 16) ^ memSeed;
    endfunction

    // Memory: acks memDelay cycles after the first cycle ramreq is seen; lateReq forces a stray ack.
    initial begin
        ramack = 1'b0;
        ramrdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            ramack = 1'b0;
            if (lateDone != lateReq) begin
                ramack = 1'b1;
                ramrdata = 8'h3C;
                lateDone++;
            end else if (ramreq) begin
                memWait++;
                if (memWait > memDelay) begin
                    ramack = 1'b1;
                    ramrdata = memByte(int'(ramaddr));
                    memWait = 0;
                end
            end else begin
                memWait = 0;
            end
        end
    end

    task automatic applyReset(input int prgU, input int chrU);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        promreq = 1'b0;
        cromreq = 1'b0;
        promaddr = '0;
        cromaddr = '0;
        header = {$urandom(), $urandom(), $urandom(), $urandom()};
        header[39:32] = 8'(prgU);
        header[47:40] = 8'(chrU);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One client read; latency counts edges from the edge that samples req to the ack.
    task automatic applyStimulus(input bit isChr, input logic [20:0] addr,
                                 output logic [7:0] data, output int latency,
                                 output bit sawRam, output logic [RAMAW-1:0] ramAddrSeen,
                                 output bit ackWide, output bit timedOut);
        sawRam = 1'b0;
        ramAddrSeen = '0;
        timedOut = 1'b0;
        if (isChr) begin
            cromaddr = addr;
            cromreq = 1'b1;
        end else begin
            promaddr = addr;
            promreq = 1'b1;
        end
        @(posedge clk);
        #1;
        latency = 0;
        while (!(isChr ? cromack : promack)) begin
            if (ramreq && !sawRam) begin
                sawRam = 1'b1;
                ramAddrSeen = ramaddr;
            end
            if (latency >= 60) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            latency++;
        end
        data = isChr ? cromdata : promdata;
        promreq = 1'b0;
        cromreq = 1'b0;
        @(posedge clk);
        #1;
        ackWide = isChr ? cromack : promack;
    endtask

    task automatic test_reset();
        applyReset(2, 1);
        total++; if (promack !== 1'b0) begin bad++; $display("[TB] FAIL reset_promack: got %b want 0", promack); end
        total++; if (cromack !== 1'b0) begin bad++; $display("[TB] FAIL reset_cromack: got %b want 0", cromack); end
        total++; if (ramreq !== 1'b0) begin bad++; $display("[TB] FAIL reset_ramreq: got %b want 0", ramreq); end
        total++; if (ramaddr !== '0) begin bad++; $display("[TB] FAIL reset_ramaddr: got %h want 0", ramaddr); end
        total++; if (promdata !== 8'h00 || cromdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h/%h want 00/00", promdata, cromdata); end
        total++; if (oob !== 2'b00) begin bad++; $display("[TB] FAIL reset_oob: got %b want 00", oob); end
    endtask

    task automatic test_prg_read();
        logic [7:0] data; int lat; bit saw, wide, to; logic [RAMAW-1:0] ra;
        applyReset(2, 1);
        memDelay = 1;
        memSeed = 8'h00;
        memSeed = 8'hA5 ^ memByte(32'h7FFF);
        applyStimulus(1'b0, 21'h07FFF, data, lat, saw, ra, wide, to);
        total++; if (to || !saw) begin bad++; $display("[TB] FAIL prg_read_ramreq: seen=%b timeout=%b want 1/0", saw, to); end
        total++; if (ra !== 23'h07FFF) begin bad++; $display("[TB] FAIL prg_read_addr: got %h want 07fff", ra); end
        total++; if (data !== 8'hA5) begin bad++; $display("[TB] FAIL prg_read_data: got %h want a5", data); end
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL prg_read_latency: got %0d want 3", lat); end
        total++; if (wide !== 1'b0) begin bad++; $display("[TB] FAIL prg_read_ackwidth: ack still high %b want 0", wide); end
        total++; if (oob !== 2'b00) begin bad++; $display("[TB] FAIL prg_read_oob: got %b want 00", oob); end
    endtask

    task automatic test_chr_read();
        logic [7:0] data; int lat; bit saw, wide, to; logic [RAMAW-1:0] ra;
        memSeed = 8'h71;
        applyStimulus(1'b1, 21'h00010, data, lat, saw, ra, wide, to);
        total++; if (ra !== 23'h08010 || !saw || to) begin bad++; $display("[TB] FAIL chr_read_addr: got %h want 08010", ra); end
        total++; if (data !== memByte(32'h8010)) begin bad++; $display("[TB] FAIL chr_read_data: got %h want %h", data, memByte(32'h8010)); end
        total++; if (lat !== 3 || wide !== 1'b0) begin bad++; $display("[TB] FAIL chr_read_timing: latency %0d wide %b want 3/0", lat, wide); end
        // Last byte of an 8KiB CHR bank is in range, the next one is not.
        applyStimulus(1'b1, 21'h01FFF, data, lat, saw, ra, wide, to);
        total++; if (ra !== 23'h09FFF || data !== memByte(32'h9FFF)) begin bad++; $display("[TB] FAIL chr_last_byte: addr %h data %h want 09fff/%h", ra, data, memByte(32'h9FFF)); end
        total++; if (oob !== 2'b00) begin bad++; $display("[TB] FAIL chr_last_byte_oob: got %b want 00", oob); end
    endtask

    task automatic test_chr_oob();
        logic [7:0] data; int lat; bit saw, wide, to; logic [RAMAW-1:0] ra;
        applyReset(2, 0);
        memDelay = 1;
        memSeed = 8'h2B;
        applyStimulus(1'b1, 21'h00000, data, lat, saw, ra, wide, to);
        total++; if (saw !== 1'b0) begin bad++; $display("[TB] FAIL chr_oob_noram: ramreq seen %b want 0", saw); end
        total++; if (lat !== 2 || to) begin bad++; $display("[TB] FAIL chr_oob_latency: got %0d want 2", lat); end
        total++; if (data !== 8'hFF) begin bad++; $display("[TB] FAIL chr_oob_data: got %h want ff", data); end
        total++; if (oob !== 2'b10) begin bad++; $display("[TB] FAIL chr_oob_flag: got %b want 10", oob); end
        applyStimulus(1'b0, 21'h00123, data, lat, saw, ra, wide, to);
        total++; if (data !== memByte(32'h123)) begin bad++; $display("[TB] FAIL chr_oob_next_data: got %h want %h", data, memByte(32'h123)); end
        total++; if (oob !== 2'b10) begin bad++; $display("[TB] FAIL chr_oob_sticky: got %b want 10", oob); end
    endtask

    task automatic test_prg_oob();
        logic [7:0] data; int lat; bit saw, wide, to; logic [RAMAW-1:0] ra;
        applyReset(2, 1);
        applyStimulus(1'b0, 21'h08000, data, lat, saw, ra, wide, to);
        total++; if (saw !== 1'b0 || to) begin bad++; $display("[TB] FAIL prg_oob_noram: ramreq seen %b want 0", saw); end
        total++; if (data !== 8'hFF || lat !== 2) begin bad++; $display("[TB] FAIL prg_oob_ack: data %h latency %0d want ff/2", data, lat); end
        total++; if (oob !== 2'b01) begin bad++; $display("[TB] FAIL prg_oob_flag: got %b want 01", oob); end
        applyStimulus(1'b1, 21'h02000, data, lat, saw, ra, wide, to);
        total++; if (oob !== 2'b11 || data !== 8'hFF) begin bad++; $display("[TB] FAIL chr_boundary_oob: oob %b data %h want 11/ff", oob, data); end
    endtask

    task automatic test_back_to_back();
        int acks, cycles;
        bit expChr, gotChr, prevP, prevC;
        logic [7:0] got, want;
        applyReset(2, 1);
        memDelay = 1;
        memSeed = 8'h5C;
        promaddr = 21'h00456;
        cromaddr = 21'h00789;
        promreq = 1'b1;
        cromreq = 1'b1;
        expChr = 1'b0;
        acks = 0;
        cycles = 0;
        prevP = 1'b0;
        prevC = 1'b0;
        while (acks < 6 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (promack && cromack) begin
                total++; bad++; $display("[TB] FAIL b2b_both_acks: cycle %0d both acks high", cycles);
            end
            if ((promack && prevP) || (cromack && prevC)) begin
                total++; bad++; $display("[TB] FAIL b2b_ack_width: cycle %0d ack held for two cycles", cycles);
            end
            if (promack || cromack) begin
                gotChr = cromack;
                got = gotChr ? cromdata : promdata;
                want = gotChr ? memByte(32'h8000 + 32'h789) : memByte(32'h456);
                total++; if (gotChr !== expChr) begin bad++; $display("[TB] FAIL b2b_order: ack %0d chr=%b want chr=%b", acks, gotChr, expChr); end
                total++; if (got !== want) begin bad++; $display("[TB] FAIL b2b_data: ack %0d got %h want %h", acks, got, want); end
                expChr = ~expChr;
                acks++;
            end
            prevP = promack;
            prevC = cromack;
        end
        promreq = 1'b0;
        cromreq = 1'b0;
        total++; if (acks != 6) begin bad++; $display("[TB] FAIL b2b_timeout: got %0d acks want 6", acks); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] data; int lat, stray; bit saw, wide, to; logic [RAMAW-1:0] ra;
        applyReset(2, 1);
        memDelay = 10;
        promaddr = 21'h00100;
        promreq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ramreq !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ramreq_before: got %b want 1", ramreq); end
        resetn = 1'b0;
        #1;
        total++; if (ramreq !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ramreq_async: got %b want 0", ramreq); end
        promreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        memDelay = 1;
        lateReq++;
        stray = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (promack || cromack || ramreq) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("[TB] FAIL rstmid_late_ack: %0d active cycles want 0", stray); end
        memSeed = 8'h9E;
        applyStimulus(1'b0, 21'h01234, data, lat, saw, ra, wide, to);
        total++; if (data !== memByte(32'h1234) || lat !== 3 || to) begin bad++; $display("[TB] FAIL rstmid_after: data %h latency %0d want %h/3", data, lat, memByte(32'h1234)); end
        stray = int'(wide);
        repeat (5) begin
            @(posedge clk);
            #1;
            if (promack) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("[TB] FAIL rstmid_single_ack: %0d extra acks want 0", stray); end
    endtask

    task automatic test_random();
        logic [7:0] data, wantData; int lat, prgU, chrU, len, addr, d, mode, expAddr;
        bit saw, wide, to, isChr, expOob; logic [RAMAW-1:0] ra; logic [1:0] oobModel;
        for (int g = 0; g < 4; g++) begin
            prgU = $urandom_range(1, 255);
            chrU = (g == 0) ? 0 : $urandom_range(0, 255);
            applyReset(prgU, chrU);
            oobModel = 2'b00;
            memSeed = 8'($urandom());
            for (int k = 0; k < 6; k++) begin
                isChr = 1'($urandom_range(0, 1));
                len = isChr ? chrU * 8192 : prgU * 16384;
                mode = $urandom_range(0, 3);
                case (mode)
                    0: addr = (len > 0) ? $urandom_range(0, len - 1) : 0;
                    1: addr = len;
                    2: addr = (len > 0) ? len - 1 : 0;
                    default: addr = $urandom_range(0, 2097151);
                endcase
                if (addr > 2097151) addr = 2097151;
                d = $urandom_range(0, 4);
                memDelay = d;
                expOob = (addr >= len);
                expAddr = (isChr ? prgU * 16384 : 0) + addr;
                wantData = expOob ? 8'hFF : memByte(expAddr);
                if (expOob) oobModel[isChr] = 1'b1;
                applyStimulus(isChr, 21'(addr), data, lat, saw, ra, wide, to);
                total++; if (data !== wantData || to) begin bad++; $display("[TB] FAIL rand_data: g%0d k%0d chr=%b addr=%h got %h want %h", g, k, isChr, addr, data, wantData); end
                total++; if (lat !== (expOob ? 2 : d + 2)) begin bad++; $display("[TB] FAIL rand_latency: g%0d k%0d got %0d want %0d", g, k, lat, expOob ? 2 : d + 2); end
                total++; if (saw !== !expOob || (!expOob && ra !== RAMAW'(expAddr))) begin bad++; $display("[TB] FAIL rand_ramaddr: g%0d k%0d seen %b addr %h want %h", g, k, saw, ra, RAMAW'(expAddr)); end
                total++; if (oob !== oobModel || wide !== 1'b0) begin bad++; $display("[TB] FAIL rand_oob: g%0d k%0d oob %b wide %b want %b/0", g, k, oob, wide, oobModel); end
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        promreq = 1'b0;
        cromreq = 1'b0;
        promaddr = '0;
        cromaddr = '0;
        header = '0;
        test_reset();
        test_prg_read();
        test_chr_read();
        test_chr_oob();
        test_prg_oob();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
